// File: rtl/mash_mc.sv
// mash_mc: CHANNELS lockstep MASH 1-1 / first-order error-feedback modulators
// with per-channel LFSR dither, per-channel enable and AXI-stream backpressure.
module mash_mc #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16
) (
  input  logic                      aclk,
  input  logic                      arst,
  input  logic                      mode,
  input  logic                      dither_enable,
  input  logic [CHANNELS-1:0]       ch_enable,
  input  logic [CHANNELS*WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [CHANNELS*3-1:0]     m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
);

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [WIDTH-1:0]      x_q       [CHANNELS];
  logic [WIDTH-1:0]      x_d       [CHANNELS];
  logic [WIDTH-1:0]      acc1_q    [CHANNELS];
  logic [WIDTH-1:0]      acc1_d    [CHANNELS];
  logic [WIDTH-1:0]      acc2_q    [CHANNELS];
  logic [WIDTH-1:0]      acc2_d    [CHANNELS];
  logic [CHANNELS-1:0]   c2p_q, c2p_d;
  logic [15:0]           lfsr_q    [CHANNELS];
  logic [15:0]           lfsr_d    [CHANNELS];
  logic [WIDTH:0]        sum1      [CHANNELS];
  logic [WIDTH:0]        sum2      [CHANNELS];
  logic [2:0]            y         [CHANNELS];
  logic [CHANNELS*3-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tready_q;
  logic                  primed_q, primed_d;
  logic                  mode_q;
  logic                  accept, mode_change, step;

  assign accept      = s_axis_tvalid && tready_q;
  assign mode_change = (mode != mode_q);
  assign step        = primed_q && (!tvalid_q || m_axis_tready) && !mode_change;

  // NOTE: every variable written here gets a default first so no path can infer a latch.
  always_comb begin
    x_d      = x_q;
    acc1_d   = acc1_q;
    acc2_d   = acc2_q;
    c2p_d    = c2p_q;
    lfsr_d   = lfsr_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    primed_d = primed_q || accept;
    for (int k = 0; k < CHANNELS; k++) begin
      sum1[k] = '0;
      sum2[k] = '0;
      y[k]    = '0;
      if (accept) x_d[k] = s_axis_tdata[k*WIDTH +: WIDTH];
      // A mode switch restarts every channel from the zero state instead of stepping.
      if (mode_change) begin
        acc1_d[k] = '0;
        acc2_d[k] = '0;
        c2p_d[k]  = 1'b0;
      end else if (step) begin
        lfsr_d[k] = (lfsr_q[k] >> 1) ^ (lfsr_q[k][0] ? LFSR_TAPS : 16'h0000);
        if (ch_enable[k]) begin
          sum1[k]   = {1'b0, acc1_q[k]} + {1'b0, x_q[k]}
                    + {{WIDTH{1'b0}}, dither_enable & lfsr_q[k][0]};
          acc1_d[k] = sum1[k][WIDTH-1:0];
          if (mode_q) begin
            sum2[k]   = {1'b0, acc2_q[k]} + {1'b0, sum1[k][WIDTH-1:0]};
            acc2_d[k] = sum2[k][WIDTH-1:0];
            c2p_d[k]  = sum2[k][WIDTH];
            y[k]      = {2'b00, sum1[k][WIDTH]} + {2'b00, sum2[k][WIDTH]}
                      - {2'b00, c2p_q[k]};
          end else begin
            acc2_d[k] = '0;
            c2p_d[k]  = 1'b0;
            y[k]      = {2'b00, sum1[k][WIDTH]};
          end
        end else begin
          acc1_d[k] = '0;
          acc2_d[k] = '0;
          c2p_d[k]  = 1'b0;
        end
        tdata_d[k*3 +: 3] = y[k];
      end
    end
    if (step) tvalid_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      // NOTE: the per-channel arrays are reset explicitly; the LFSRs must never start at zero.
      x_q      <= '{default: '0};
      acc1_q   <= '{default: '0};
      acc2_q   <= '{default: '0};
      for (int k = 0; k < CHANNELS; k++) lfsr_q[k] <= LFSR_SEED ^ 16'(k);
      c2p_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tready_q <= 1'b0;
      primed_q <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      x_q      <= x_d;
      acc1_q   <= acc1_d;
      acc2_q   <= acc2_d;
      lfsr_q   <= lfsr_d;
      c2p_q    <= c2p_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tready_q <= 1'b1;
      primed_q <= primed_d;
      mode_q   <= mode;
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_mash_mc.sv
// Directed self-checking bench for mash_mc (CHANNELS=2, WIDTH=16); inputs are
// driven and outputs sampled on the falling clock edge.
module tb_mash_mc;

  logic        aclk = 1'b0;
  logic        arst;
  logic        mode;
  logic        dither_enable;
  logic [1:0]  ch_enable;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [5:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;

  int total = 0;
  int bad   = 0;

  // Expected MASH 1-1 output for a constant half-scale input from the zero state.
  int p1 [4] = '{0, 1, 1, 0};

  mash_mc #(.CHANNELS(2), .WIDTH(16)) dut (
    .aclk          (aclk),
    .arst          (arst),
    .mode          (mode),
    .dither_enable (dither_enable),
    .ch_enable     (ch_enable),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge aclk);
  endtask

  function automatic int y_of(input int ch);
    logic [2:0] f;
    f = m_tdata[ch*3 +: 3];
    return int'($signed(f));
  endfunction

  // Reset, then accept one sample on both channels; returns just after the accept edge.
  task automatic start(input logic [15:0] xv, input logic md, input logic dith);
    arst = 1'b1; s_tvalid = 1'b0; mode = md; dither_enable = dith;
    ch_enable = 2'b11; m_tready = 1'b1;
    #1;
    check("rst_tvalid", int'(m_tvalid), 0);
    check("rst_tdata",  int'(m_tdata), 0);
    check("rst_tready", int'(s_tready), 0);
    cyc();
    arst = 1'b0;
    cyc();
    s_tdata = {xv, xv}; s_tvalid = 1'b1;
    cyc();
    s_tvalid = 1'b0;
    check("latency_tvalid", int'(m_tvalid), 0);
  endtask

  initial begin
    int sum0, sum1, range_bad, diffs;
    arst = 1'b1; mode = 1'b0; dither_enable = 1'b0; ch_enable = 2'b11;
    s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;
    cyc();
    check("in_rst_tready", int'(s_tready), 0);
    check("in_rst_tvalid", int'(m_tvalid), 0);
    arst = 1'b0;
    repeat (20) cyc();
    check("idle_tvalid", int'(m_tvalid), 0);
    check("idle_tready", int'(s_tready), 1);
    check("idle_tdata",  int'(m_tdata), 0);

    // Mode 0, x = 0x8000: 0,1,0,1,...
    s_tdata = 32'h8000_8000; s_tvalid = 1'b1;
    cyc();
    s_tvalid = 1'b0;
    check("m0_latency", int'(m_tvalid), 0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("m0_tvalid", int'(m_tvalid), 1);
      check("m0_y0", y_of(0), i % 2);
      check("m0_y1", y_of(1), i % 2);
    end

    // Switch to mode 1: one held cycle, then the sequence as from reset.
    mode = 1'b1;
    cyc();
    check("modechg_hold_y0", y_of(0), 1);
    check("modechg_hold_y1", y_of(1), 1);
    check("modechg_tvalid", int'(m_tvalid), 1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("m1_y0", y_of(0), p1[i % 4]);
      check("m1_y1", y_of(1), p1[i % 4]);
    end

    // Backpressure: frozen for 5 cycles, then resume without skip or repeat.
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bp_y0", y_of(0), 1);
      check("bp_y1", y_of(1), 1);
    end
    m_tready = 1'b1;
    for (int i = 6; i < 10; i++) begin
      cyc();
      check("bp_resume_y0", y_of(0), p1[i % 4]);
      check("bp_resume_y1", y_of(1), p1[i % 4]);
    end

    // Disable channel 1, then re-enable it from the zero state.
    ch_enable = 2'b01;
    for (int i = 10; i < 14; i++) begin
      cyc();
      check("dis_y0", y_of(0), p1[i % 4]);
      check("dis_y1", y_of(1), 0);
    end
    ch_enable = 2'b11;
    for (int m = 0; m < 4; m++) begin
      cyc();
      check("reen_y0", y_of(0), p1[(14 + m) % 4]);
      check("reen_y1", y_of(1), p1[m]);
    end

    // Mode 1, x = 0: all zero.
    start(16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("zero_tvalid", int'(m_tvalid), 1);
      check("zero_y0", y_of(0), 0);
      check("zero_y1", y_of(1), 0);
    end

    // Mode 1, x = 0xFFFF over 65536 steps.
    start(16'hFFFF, 1'b1, 1'b0);
    sum0 = 0; sum1 = 0; range_bad = 0;
    for (int i = 0; i < 65536; i++) begin
      cyc();
      if (y_of(0) < -1 || y_of(0) > 2) range_bad++;
      if (y_of(1) < -1 || y_of(1) > 2) range_bad++;
      sum0 += y_of(0);
      sum1 += y_of(1);
    end
    check("ffff_range", range_bad, 0);
    check("ffff_sum0", int'(sum0 == 65535 || sum0 == 65536), 1);
    check("ffff_sum1", int'(sum1 == 65535 || sum1 == 65536), 1);

    // Dither on, mode 1, x = 0x8000 over 4096 steps.
    start(16'h8000, 1'b1, 1'b1);
    sum0 = 0; sum1 = 0; diffs = 0;
    for (int i = 0; i < 4096; i++) begin
      cyc();
      sum0 += y_of(0);
      sum1 += y_of(1);
      if (y_of(0) != y_of(1)) diffs++;
    end
    check("dith_channels_differ", int'(diffs > 0), 1);
    check("dith_mean0", int'(sum0 >= 2008 && sum0 <= 2088), 1);
    check("dith_mean1", int'(sum1 >= 2008 && sum1 <= 2088), 1);

    // Asynchronous reset mid-run, then no output without a new input.
    arst = 1'b1;
    #1;
    check("midrst_tvalid", int'(m_tvalid), 0);
    check("midrst_tdata",  int'(m_tdata), 0);
    cyc();
    arst = 1'b0;
    repeat (5) cyc();
    check("postrst_tvalid", int'(m_tvalid), 0);
    check("postrst_tready", int'(s_tready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mash_mc.md
# mash_mc

Multi-channel, parametrised successor to the single-channel MASH 1-1 stage in the DAC datapath. It runs CHANNELS independent error-feedback modulators in lockstep, generalising the fixed I/Q pair. Each channel has runtime-selectable first-order or MASH 1-1 mode, per-channel LFSR dither, per-channel enable, and AXI-stream output backpressure. It sits between the NCO bank and the per-channel mod2/upconverter stages.

## Interface
- CHANNELS, 2: number of independent modulator channels (1..16).
- WIDTH, 16: unsigned input sample width; also the accumulator width.
- aclk  in  1  sole clock; all state updates on the rising edge.
- arst  in  1  reset, asynchronous and active-high.
- mode  in  1  0 = first-order, 1 = MASH 1-1; applies to all channels.
- dither_enable  in  1  adds the per-channel LFSR bit to the stage-1 sum.
- ch_enable  in  CHANNELS  per-channel enable.
- s_axis_tdata  in  CHANNELS*WIDTH  unsigned samples; channel k is in bits [k*WIDTH +: WIDTH].
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tready  out  1  constant 1 after reset release.
- m_axis_tdata  out  CHANNELS*3  per-channel 3-bit two's-complement output in [k*3 +: 3].
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.

## Operation
- Hold register x[k] loads on s_axis_tvalid&&s_axis_tready.
  - A later sample overwrites it.
  - Without new input, the last sample is reused every step (zero-order hold).
- primed flag: cleared by reset, set on the first accepted input.
- step = primed && (!m_axis_tvalid || m_axis_tready) && !mode_change.
- mode_q registers mode. mode_change = (mode != mode_q).
  - On a mode_change edge: every acc1, acc2 and c2_prev clears to 0; mode_q updates; no step occurs; m_axis_tdata and m_axis_tvalid hold their values.
- Per channel, on step:
  - {c1, acc1} <= acc1 + x + d, with WIDTH+1-bit sum. d = LFSR bit 0 if dither_enable, else 0.
  - {c2, acc2} <= acc2 + acc1_new, where acc1_new is the updated acc1 from the same step.
  - mode 1: y = c1 + c2 - c2_prev, range -1..2; c2_prev <= c2.
  - mode 0: y = c1, range 0..1; acc2 and c2_prev hold at 0.
  - y is registered into m_axis_tdata as 3-bit two's complement. m_axis_tvalid <= 1.
- Disabled channel (ch_enable[k]=0): acc1, acc2 and c2_prev forced to 0 on every step; its output field is 0. Re-enabling starts from the zero state.
- LFSR: 16-bit Galois, taps 0xB400, shifts once per step only.
  - Reset seed is 0xACE1 ^ k for channel k.
  - Never all-zero.
- Wrap-around: accumulator overflow is the carry by design; no saturation anywhere.
- When step is false, all state holds, including the LFSRs.

## Timing
- Reset values:
  - acc1, acc2, c2_prev = 0; primed = 0; mode_q = 0.
  - m_axis_tvalid = 0; m_axis_tdata = 0; s_axis_tready = 0 during reset, 1 from the first edge after release.
  - LFSR = seed.
- Latency: a sample accepted at edge n affects the output registered at edge n+1. The first m_axis_tvalid rises at edge n+1 after the first accept.
- Throughput: one output per cycle while m_axis_tready=1.
- While m_axis_tvalid && !m_axis_tready, m_axis_tdata is stable and no modulator state advances.
- m_axis_tvalid, once high, stays high until reset.
- Simultaneous input accept and step at the same edge: the step uses the old x; the new x is used from the next step.
- Simultaneous mode change and input accept: x loads; the clear takes priority over the step.
- Reset asserted mid-stream: all state returns to its reset value immediately (asynchronous). After release, the block waits for a new input before any output.

## Test plan
- Run after reset with no s_axis_tvalid for 20 cycles -> m_axis_tvalid=0, s_axis_tready=1, outputs 0.
- Mode 0, no dither, x=0x8000 on both channels, tready=1 -> both outputs 0,1,0,1,... starting at the first valid edge. Mode 1 on the same input -> repeating 0,1,1,0.
- Mode 1, x=0x0000 -> all outputs 0. Mode 1, x=0xFFFF for 65536 steps -> every y in {-1..2} and the sum of y is 65535 or 65536.
- Deassert m_axis_tready for 5 cycles mid-stream (mode 1, x=0x8000) -> tdata frozen; after release the 0,1,1,0 sequence resumes without a skipped or repeated step.
- Toggle mode mid-stream -> exactly one held cycle; accumulators restart from 0; the new mode's sequence starts exactly as from reset. Deassert ch_enable[1] -> channel 1 outputs 0 while channel 0 is unaffected.
- Dither on, x=0x8000, 4096 steps -> channel 0 and channel 1 sequences differ, and the mean of y is within ±0.01 of 0.5. Assert arst mid-run -> all outputs 0 and tvalid=0 immediately.
